// File: rtl/serial_uart_tx_if.sv
// Memory-bus and bounds-check interfaces shared by the MMIO devices on a ring stop.
interface mem_if;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        read_en;
    logic        write_en;
    logic        hit;
    logic        done;

    modport bus (
        input  addr, data_i, read_en, write_en,
        output hit, done, data_o
    );
endinterface

interface mem_bounds;
    logic [31:0] check_addr;
    logic        in_bounds;

    modport server (
        input  check_addr,
        output in_bounds
    );
endinterface

// File: rtl/serial_uart_tx.sv
// MMIO 8N1 UART transmitter: TX FIFO, programmable baud divisor, DATA/STATUS/DIV/CTRL registers.
// Define SERIAL_TX_IRQ_EN to enable the registered tx_irq output (otherwise tied low).
`ifndef SERIAL_MEM_BASE
`define SERIAL_MEM_BASE 32'h1000_0100
`endif
`ifndef SERIAL_MEM_SIZE
`define SERIAL_MEM_SIZE 32'd16
`endif

module serial_uart_tx #(
    parameter logic [31:0] BASE       = `SERIAL_MEM_BASE,
    parameter logic [31:0] SIZE       = `SERIAL_MEM_SIZE,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned DIV_RESET  = 867
) (
    input  logic      clk,
    input  logic      reset,
    mem_if.bus        mem_in_port,
    mem_bounds.server bounds_checker,
    output logic      tx,
    output logic      tx_irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [32:0] WIN_LO = {1'b0, BASE};
    localparam logic [32:0] WIN_HI = {1'b0, BASE} + {1'b0, SIZE};
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_RESET);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] div_cur_q, div_cur_d;
    logic [DIV_WIDTH-1:0] timer_q, timer_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shreg_q, shreg_d;
    logic [7:0]           fifo_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 irq_en_q, irq_en_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q;
    logic                 tx_q, tx_d;
    logic [31:0]          rdata_q, rdata_d;

    logic        req_ok, hit, rd, wr, reg_sel;
    logic [31:0] offset, rmux, status;
    logic [1:0]  reg_idx;
    logic        full, empty, busy, push, push_ok, pop;
    logic        unused_bits;

    assign bounds_checker.in_bounds = ({1'b0, bounds_checker.check_addr} >= WIN_LO) &&
                                      ({1'b0, bounds_checker.check_addr} <  WIN_HI);
    assign req_ok  = ({1'b0, mem_in_port.addr} >= WIN_LO) && ({1'b0, mem_in_port.addr} < WIN_HI);
    assign hit     = (mem_in_port.read_en | mem_in_port.write_en) & req_ok;
    assign rd      = mem_in_port.read_en & req_ok;
    assign wr      = mem_in_port.write_en & req_ok;
    assign offset  = mem_in_port.addr - BASE;
    assign reg_sel = (offset[31:4] == '0);
    assign reg_idx = offset[3:2];

    assign full    = (cnt_q == DEPTH_C);
    assign empty   = (cnt_q == '0);
    assign busy    = (state_q != S_IDLE);
    assign push_ok = push & ~full;
    assign status  = {16'h0000, 8'(cnt_q), 3'b000, irq_en_q, ovf_q, busy, empty, full};

    assign unused_bits = ^{offset[1:0], mem_in_port.data_i};

    always_comb begin
        rmux = '0;
        unique case (reg_idx)
            2'd1:    rmux = status;
            2'd2:    rmux = 32'(div_q);
            2'd3:    rmux = {31'b0, irq_en_q};
            default: rmux = '0;
        endcase
    end

    always_comb begin
        div_d    = div_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        rdata_d  = rdata_q;
        push     = 1'b0;
        if (hit) rdata_d = reg_sel ? rmux : '0;
        if (wr && reg_sel) begin
            unique case (reg_idx)
                2'd0:    push = 1'b1;
                2'd2:    div_d = mem_in_port.data_i[DIV_WIDTH-1:0];
                2'd3:    irq_en_d = mem_in_port.data_i[0];
                default: ;
            endcase
        end
        if (rd && reg_sel && reg_idx == 2'd1) ovf_d = 1'b0;
        if (push && full) ovf_d = 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        div_cur_d = div_cur_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        pop       = 1'b0;
        tx_d      = 1'b1;
        unique case (state_q)
            S_IDLE:  pop = !empty;
            S_START: begin
                if (timer_q == '0) begin
                    state_d = S_DATA;
                    timer_d = div_cur_q;
                    bit_d   = '0;
                end else timer_d = timer_q - 1'b1;
            end
            S_DATA: begin
                if (timer_q == '0) begin
                    timer_d = div_cur_q;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end else timer_d = timer_q - 1'b1;
            end
            S_STOP: begin
                if (timer_q == '0) begin
                    if (!empty) pop = 1'b1;
                    else        state_d = S_IDLE;
                end else timer_d = timer_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // Loading straight from STOP lets consecutive frames run with no idle cycle between them.
        if (pop) begin
            state_d   = S_START;
            timer_d   = div_q;
            div_cur_d = div_q;
            shreg_d   = fifo_q[rptr_q];
        end
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            div_cur_q <= DIV_RST;
            bit_q     <= '0;
            shreg_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            div_q     <= DIV_RST;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_cur_q <= div_cur_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            done_q    <= hit;
            rdata_q   <= rdata_d;
            tx_q      <= tx_d;
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wptr_q] <= mem_in_port.data_i[7:0];
    end

`ifdef SERIAL_TX_IRQ_EN
    logic tx_irq_q;
    always_ff @(posedge clk) begin
        if (reset) tx_irq_q <= 1'b0;
        else       tx_irq_q <= irq_en_q & empty & ~busy;
    end
    assign tx_irq = tx_irq_q;
`else
    assign tx_irq = 1'b0;
`endif

    assign mem_in_port.hit    = hit;
    assign mem_in_port.done   = done_q;
    assign mem_in_port.data_o = rdata_q;
    assign tx                 = tx_q;
endmodule

// File: tb/tb_serial_uart_tx.sv
// Scoreboard bench for serial_uart_tx: register reads and UART frames are checked by monitors.
module tb_serial_uart_tx;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam logic [31:0] SIZE  = 32'd32;
    localparam int          DEPTH = 16;
`ifdef SERIAL_TX_IRQ_EN
    localparam logic IRQV     = 1'b1;
    localparam int   EXP_RISE = 42;
`else
    localparam logic IRQV     = 1'b0;
    localparam int   EXP_RISE = -1;
`endif

    typedef struct { bit chk; logic [31:0] val; string name; } rd_t;
    typedef struct { logic [7:0] b; int div; bit b2b; } fr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx, tx_irq;
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    rd_t  rq[$];
    fr_t  txq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_if     mif();
    mem_bounds mb();

    serial_uart_tx #(
        .BASE(BASE), .SIZE(SIZE), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16), .DIV_RESET(867)
    ) dut (
        .clk(clk), .reset(reset), .mem_in_port(mif), .bounds_checker(mb),
        .tx(tx), .tx_irq(tx_irq)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
        mif.addr = a; mif.data_i = d; mif.write_en = we; mif.read_en = re;
        @(posedge clk);
        #1;
        mif.write_en = 1'b0; mif.read_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        rq.push_back('{chk: 1'b0, val: 32'h0, name: "write"});
        bus(1'b1, 1'b0, BASE + off, d);
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string nm);
        rq.push_back('{chk: 1'b1, val: exp, name: nm});
        bus(1'b0, 1'b1, BASE + off, 32'h0);
    endtask

    task automatic push_byte(input logic [7:0] b, input int div, input bit b2b);
        txq.push_back('{b: b, div: div, b2b: b2b});
        wr(32'h0, {24'h0, b});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        txq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Register scoreboard: every done must follow a hit by one cycle and match the queued read.
    initial begin : regmon
        bit  hit_prev;
        rd_t it;
        hit_prev = 1'b0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (mif.done || hit_prev) begin
                chk("done_latency", mif.done, hit_prev);
                if (mif.done) begin
                    if (rq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", cyc);
                    end else begin
                        it = rq.pop_front();
                        if (it.chk) chk(it.name, mif.data_o, it.val);
                    end
                end
            end
            hit_prev = mif.hit;
        end
    end

    // Frame scoreboard: each start bit is matched to the next expected byte, checked cycle by cycle.
    initial begin : txmon
        fr_t        f;
        bit         bad, aborted;
        int         start_cyc, last_end;
        logic [9:0] bits;
        last_end = -100;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                start_cyc = cyc;
                if (txq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame: tx low at cycle %0d, expected idle high", cyc);
                    for (int n = 0; n < 20000 && tx === 1'b0 && !reset; n++) @(negedge clk);
                end else begin
                    f = txq.pop_front();
                    bits = {1'b1, f.b, 1'b0};
                    bad = 1'b0;
                    aborted = 1'b0;
                    if (f.b2b) chk("b2b_gap_start_cycle", start_cyc, last_end + 1);
                    for (int k = 0; k < 10 && !aborted; k++) begin
                        for (int r = 0; r <= f.div && !aborted; r++) begin
                            if (!(k == 0 && r == 0)) begin
                                @(negedge clk);
                                if (reset) aborted = 1'b1;
                            end
                            if (!aborted && tx !== bits[k]) bad = 1'b1;
                        end
                    end
                    if (!aborted) begin
                        last_end = cyc;
                        chk($sformatf("frame_0x%02h_mismatch", f.b), {31'b0, bad}, 32'h0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] v, a;
        logic [63:0] a64;
        logic [7:0]  b;
        int          d, n, fall_k, rise_k;
        logic [31:0] bound_addrs [8];

        mif.addr = '0; mif.data_i = '0; mif.read_en = 1'b0; mif.write_en = 1'b0;
        mb.check_addr = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_done", mif.done, 0);
        chk("rst_data_o", mif.data_o, 0);
        chk("rst_tx_irq", tx_irq, 0);
        @(posedge clk);
        #1;

        rd(32'h8, 32'd867, "div_reset");
        rd(32'h4, 32'h0002, "status_reset");
        rd(32'hC, 32'h0, "ctrl_reset");
        rd(32'h0, 32'h0, "data_reads_zero");
        rd(32'h14, 32'h0, "unmapped_offset_zero");

        mif.addr = BASE + SIZE; mif.read_en = 1'b1;
        #1 chk("hit_above_window", mif.hit, 0);
        mif.addr = BASE - 32'd4;
        #1 chk("hit_below_window", mif.hit, 0);
        mif.read_en = 1'b0;

        bound_addrs[0] = BASE - 1;        bound_addrs[1] = BASE;
        bound_addrs[2] = BASE + SIZE - 1; bound_addrs[3] = BASE + SIZE;
        bound_addrs[4] = 32'h0;           bound_addrs[5] = 32'hFFFF_FFFF;
        bound_addrs[6] = BASE + 32'(($urandom % SIZE));
        bound_addrs[7] = $urandom;
        for (int i = 0; i < 8; i++) begin
            a = bound_addrs[i];
            a64 = {32'h0, a};
            mb.check_addr = a;
            #1 chk($sformatf("in_bounds_0x%08h", a), {31'b0, mb.in_bounds},
                   {31'b0, (a64 >= {32'h0, BASE}) && (a64 < {32'h0, BASE} + {32'h0, SIZE})});
        end
        @(posedge clk);
        #1;

        v = $urandom;
        wr(32'h8, v);
        rd(32'h8, {16'h0, v[15:0]}, "div_random_rb");

        wr(32'h8, 32'd3);
        rd(32'h8, 32'd3, "div_rb_3");
        push_byte(8'h41, 3, 1'b0);
        wait_cyc(5);
        rd(32'h4, 32'h0006, "status_busy");
        wait_cyc(50);
        rd(32'h4, 32'h0002, "status_idle_after_frame");
        chk("frames_left_0x41", txq.size(), 0);

        wr(32'h8, 32'd0);
        push_byte(8'h55, 0, 1'b0);
        push_byte(8'hAA, 0, 1'b1);
        wait_cyc(40);
        chk("frames_left_div0", txq.size(), 0);

        wr(32'h8, 32'd2);
        push_byte(8'h3C, 2, 1'b0);
        push_byte(8'hC3, 1, 1'b1);
        wr(32'h8, 32'd1);
        wait_cyc(80);
        chk("frames_left_divchange", txq.size(), 0);

        for (int r = 0; r < 6; r++) begin
            d = $urandom_range(0, 4);
            n = $urandom_range(1, 5);
            wr(32'h8, d);
            rd(32'h8, d, "div_round_rb");
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                push_byte(b, d, i > 0);
            end
            wait_cyc(n * 10 * (d + 1) + 20);
            rd(32'h4, 32'h0002, "status_round_drained");
            chk("frames_left_round", txq.size(), 0);
        end

        wr(32'hC, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("irq_before_enable_seen", tx_irq, 0);
        @(negedge clk);
        chk("irq_after_enable", tx_irq, IRQV);
        @(posedge clk);
        #1;
        rd(32'hC, 32'h1, "ctrl_rb");
        rd(32'h4, 32'h0012, "status_irq_en");

        wr(32'h8, 32'd3);
        push_byte(8'h30, 3, 1'b0);
        chk("irq_before_push_seen", tx_irq, IRQV);
        fall_k = -1;
        rise_k = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (fall_k < 0 && !tx_irq) fall_k = k;
            else if (fall_k >= 0 && rise_k < 0 && tx_irq) rise_k = k;
        end
        chk("irq_fall_cycle", fall_k, 1);
        chk("irq_rise_cycle", rise_k, EXP_RISE);
        chk("frames_left_irq", txq.size(), 0);

        wr(32'hC, 32'h0);
        @(negedge clk);
        chk("irq_disable_lag", tx_irq, IRQV);
        @(negedge clk);
        chk("irq_after_disable", tx_irq, 0);
        @(posedge clk);
        #1;

        wr(32'h8, 32'd1000);
        for (int i = 0; i < 18; i++) begin
            b = 8'($urandom);
            if (i < 17) push_byte(b, 1000, i > 0);
            else        wr(32'h0, {24'h0, b});
        end
        rd(32'h4, 32'h0000_100D, "status_full_overflow");
        rd(32'h4, 32'h0000_1005, "status_overflow_cleared");
        wait_cyc(2);
        do_reset();
        rd(32'h8, 32'd867, "div_after_reset");

        wr(32'h8, 32'd3);
        push_byte(8'h0F, 3, 1'b0);
        for (int i = 0; i < 3; i++) push_byte(8'($urandom), 3, 1'b1);
        wait_cyc(8);
        do_reset();
        @(negedge clk);
        chk("tx_after_midframe_reset", tx, 1);
        chk("irq_after_midframe_reset", tx_irq, 0);
        @(posedge clk);
        #1;
        rd(32'h4, 32'h0002, "status_after_midframe_reset");
        rd(32'hC, 32'h0, "ctrl_after_midframe_reset");
        wait_cyc(200);
        chk("reads_outstanding", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
